// File: rtl/spi_master_engine_if.sv
// SPI master engine bundle: controller handshake, transfer config and SPI pins.
// Latency: none (wires only).
// Backpressure: start is only honoured while busy is low; no queuing.
interface spi_master_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic [1:0]            mode;       // {CPOL, CPHA}
    logic                  lsb_first;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  sck;
    logic                  mosi;
    logic                  miso;
    logic                  cs_n;

    // Engine side: owns the SPI pins and the status outputs.
    modport master (
        input  start, tx_data, mode, lsb_first, miso,
        output busy, done, rx_data, sck, mosi, cs_n
    );

    // Controller/device side: requests transfers and answers on miso.
    modport slave (
        output start, tx_data, mode, lsb_first, miso,
        input  busy, done, rx_data, sck, mosi, cs_n
    );
endinterface

// File: rtl/spi_master_engine.sv
// Parametrised SPI master with runtime CPOL/CPHA, bit order and CS framing.
// Latency: done pulses (2*DATA_WIDTH+2)*HALF_PERIOD clk edges after acceptance.
// Backpressure: start is ignored while busy; one frame at a time, no queuing.
module spi_master_engine #(
    parameter int DATA_WIDTH  = 8,
    parameter int HALF_PERIOD = 16,
    parameter int CNT_WIDTH   = 5
) (
    input  logic                clk,
    input  logic                reset,
    spi_master_engine_if.master bus
);
    // One extra bit so the toggle counter never wraps before the compare.
    localparam int                   TOG_WIDTH = $clog2(2 * DATA_WIDTH) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(HALF_PERIOD - 1);
    localparam logic [TOG_WIDTH-1:0] TOG_LAST  = TOG_WIDTH'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t                state, state_nxt;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [TOG_WIDTH-1:0]  tog_cnt;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  cpol_q, cpha_q, lsb_q;
    logic                  busy_q, done_q, sck_q, mosi_q, cs_n_q;

    logic half_end, accept, toggle, lead, last_tog, finish, drive, sample;

    // Bit currently at the transmit end of a word for the chosen order.
    function automatic logic pick_bit(input logic [DATA_WIDTH-1:0] d, input logic lsb);
        return lsb ? d[0] : d[DATA_WIDTH-1];
    endfunction

    // Word with the transmitted bit removed from the transmit end.
    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] d,
                                                      input logic lsb);
        return lsb ? (d >> 1) : (d << 1);
    endfunction

    // MSB-first frames fill from the LSB end; LSB-first frames fill from the MSB end.
    function automatic logic [DATA_WIDTH-1:0] capture(input logic [DATA_WIDTH-1:0] d,
                                                      input logic lsb, input logic b);
        return lsb ? ((d >> 1) | (DATA_WIDTH'(b) << (DATA_WIDTH - 1)))
                   : ((d << 1) | DATA_WIDTH'(b));
    endfunction

    assign half_end = (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state plus per-edge strobes that steer the datapath.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        toggle    = 1'b0;
        last_tog  = 1'b0;
        finish    = 1'b0;
        lead      = ~tog_cnt[0];  // toggles 1,3,5.. (count 0,2,4..) are leading edges
        drive     = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (half_end) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (half_end) begin
                    toggle = 1'b1;
                    if (tog_cnt == TOG_LAST) begin
                        last_tog  = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (half_end) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // CPHA=0 already presented bit 0 at acceptance, so the final trailing edge has nothing to drive.
        drive  = toggle & (cpha_q ? lead : (~lead & ~last_tog));
        sample = toggle & (cpha_q ? ~lead : lead);
    end

    // Half-period counter: idles at zero, restarts at every terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        cnt <= '0;
        else if (state == IDLE || half_end) cnt <= '0;
        else                              cnt <= cnt + CNT_WIDTH'(1);
    end

    // Frame datapath: config latch, SCK generation, shift registers and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            tog_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                cpol_q   <= bus.mode[1];
                cpha_q   <= bus.mode[0];
                lsb_q    <= bus.lsb_first;
                busy_q   <= 1'b1;
                cs_n_q   <= 1'b0;
                sck_q    <= bus.mode[1];
                tog_cnt  <= '0;
                rx_shift <= '0;
                if (!bus.mode[0]) begin
                    mosi_q   <= pick_bit(bus.tx_data, bus.lsb_first);
                    tx_shift <= advance(bus.tx_data, bus.lsb_first);
                end else begin
                    tx_shift <= bus.tx_data;
                end
            end
            if (toggle) begin
                sck_q   <= ~sck_q;
                tog_cnt <= tog_cnt + TOG_WIDTH'(1);
            end
            if (drive) begin
                mosi_q   <= pick_bit(tx_shift, lsb_q);
                tx_shift <= advance(tx_shift, lsb_q);
            end
            if (sample) rx_shift <= capture(rx_shift, lsb_q, bus.miso);
            if (finish) begin
                cs_n_q    <= 1'b1;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                rx_data_q <= rx_shift;
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
    assign bus.sck     = sck_q;
    assign bus.mosi    = mosi_q;
    assign bus.cs_n    = cs_n_q;

    // Keep the config latch observable for the idle SCK level.
    logic unused_cpol;
    assign unused_cpol = cpol_q;
endmodule

// File: tb/tb_spi_master_engine.sv
// Self-checking bench for spi_master_engine: default 8-bit/16-cycle engine
// against a mode-aware SPI slave model, plus a 4-bit/1-cycle engine in loopback
// for back-to-back framing.
`timescale 1ns/1ps
module tb_spi_master_engine;
    localparam int W  = 8;
    localparam int HP = 16;
    localparam int FW = 4;
    localparam int FRAME_EDGES = (2 * W + 2) * HP;  // 288

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    spi_master_engine_if #(.DATA_WIDTH(W))  bus ();
    spi_master_engine_if #(.DATA_WIDTH(FW)) fbus ();

    spi_master_engine #(.DATA_WIDTH(W), .HALF_PERIOD(HP), .CNT_WIDTH(5)) u_dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    spi_master_engine #(.DATA_WIDTH(FW), .HALF_PERIOD(1), .CNT_WIDTH(1)) u_fast (
        .clk(clk), .reset(reset), .bus(fbus)
    );

    assign fbus.miso = fbus.mosi;

    int errors = 0;
    int checks = 0;

    // Scoreboards: expected master rx and expected word seen by the slave.
    logic [W-1:0]  exp_rx_q[$];
    logic [W-1:0]  exp_tx_q[$];
    logic [FW-1:0] fexp_q[$];

    // Slave model state.
    logic         slv_cpol = 1'b0, slv_cpha = 1'b0, slv_lsb = 1'b0;
    logic [W-1:0] slv_reply = '0, slv_sh = '0, slv_rx = '0;
    logic         slv_first = 1'b0;
    int           slv_edges = 0, slv_samples = 0;
    logic         prev_sck = 1'b0, prev_cs_n = 1'b1;

    // Mode-aware SPI slave, evaluated on the falling clk edge.
    always @(negedge clk) begin
        if (reset) begin
            bus.miso  = 1'b0;
            prev_sck  = 1'b0;
            prev_cs_n = 1'b1;
        end else begin
            if (bus.cs_n === 1'b0 && prev_cs_n === 1'b1) begin
                slv_sh = slv_reply; slv_rx = '0; slv_edges = 0; slv_samples = 0;
                if (!slv_cpha) begin
                    bus.miso = slv_lsb ? slv_sh[0] : slv_sh[W-1];
                    slv_sh   = slv_lsb ? (slv_sh >> 1) : (slv_sh << 1);
                end
            end else if (bus.cs_n === 1'b0 && bus.sck !== prev_sck) begin
                slv_edges++;
                if ((bus.sck !== slv_cpol) == !slv_cpha) begin
                    if (slv_samples == 0) slv_first = bus.mosi;
                    slv_rx = slv_lsb ? {bus.mosi, slv_rx[W-1:1]} : {slv_rx[W-2:0], bus.mosi};
                    slv_samples++;
                end else begin
                    bus.miso = slv_lsb ? slv_sh[0] : slv_sh[W-1];
                    slv_sh   = slv_lsb ? (slv_sh >> 1) : (slv_sh << 1);
                end
            end
            prev_sck  = bus.sck;
            prev_cs_n = bus.cs_n;
        end
    end

    // Drive one start pulse to the idle default engine; returns just after acceptance.
    task automatic start_frame(input logic [W-1:0] tx, input logic [1:0] m,
                               input logic lsb, input logic [W-1:0] reply);
        @(negedge clk);
        slv_cpol = m[1]; slv_cpha = m[0]; slv_lsb = lsb; slv_reply = reply;
        bus.tx_data = tx; bus.mode = m; bus.lsb_first = lsb; bus.start = 1'b1;
        exp_rx_q.push_back(reply);
        exp_tx_q.push_back(tx);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Count edges from acceptance until done, noting any cs_n release before it.
    task automatic wait_done(input int budget, output int n, output bit cs_glitch);
        n = 0; cs_glitch = 1'b0;
        while (bus.done !== 1'b1 && n < budget) begin
            if (bus.cs_n !== 1'b0) cs_glitch = 1'b1;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.tx_data = '0; bus.mode = 2'b00; bus.lsb_first = 1'b0;
        fbus.start = 1'b0; fbus.tx_data = '0; fbus.mode = 2'b00; fbus.lsb_first = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx: got %h expected 00", bus.rx_data); end
        checks++; if (bus.sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", bus.sck); end
        checks++; if (bus.mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", bus.mosi); end
        checks++; if (bus.cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", bus.cs_n); end
        checks++; if (fbus.cs_n !== 1'b1) begin errors++; $display("FAIL reset_fast_cs_n: got %b expected 1", fbus.cs_n); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0;
        int n; bit gl; logic [W-1:0] e;
        start_frame(8'hA5, 2'b00, 1'b0, 8'h3C);
        checks++; if (bus.cs_n !== 1'b0) begin errors++; $display("FAIL m0_cs_low_edge0: got %b expected 0", bus.cs_n); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL m0_busy_edge0: got %b expected 1", bus.busy); end
        checks++; if (bus.mosi !== 1'b1) begin errors++; $display("FAIL m0_first_mosi: got %b expected 1", bus.mosi); end
        wait_done(FRAME_EDGES + 20, n, gl);
        checks++; if (n != FRAME_EDGES) begin errors++; $display("FAIL m0_done_edge: got %0d expected %0d", n, FRAME_EDGES); end
        checks++; if (gl !== 1'b0) begin errors++; $display("FAIL m0_cs_window: got release before done, expected none"); end
        checks++; if (bus.busy !== 1'b0 || bus.cs_n !== 1'b1) begin errors++; $display("FAIL m0_end_status: got busy=%b cs_n=%b expected 0/1", bus.busy, bus.cs_n); end
        e = exp_rx_q.pop_front();
        checks++; if (bus.rx_data !== e) begin errors++; $display("FAIL m0_rx: got %h expected %h", bus.rx_data, e); end
        e = exp_tx_q.pop_front();
        checks++; if (slv_rx !== e) begin errors++; $display("FAIL m0_mosi_bits: got %h expected %h", slv_rx, e); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL m0_done_width: got %b expected 0", bus.done); end
    endtask

    task automatic test_modes;
        int n; bit gl; logic [W-1:0] e;
        for (int m = 0; m < 4; m++) begin
            start_frame(8'h81, 2'(m), 1'b0, 8'h7E);
            checks++; if (bus.sck !== 1'(m >> 1)) begin errors++; $display("FAIL mode%0d_sck_start: got %b expected %b", m, bus.sck, 1'(m >> 1)); end
            wait_done(FRAME_EDGES + 20, n, gl);
            checks++; if (n != FRAME_EDGES) begin errors++; $display("FAIL mode%0d_done_edge: got %0d expected %0d", m, n, FRAME_EDGES); end
            e = exp_rx_q.pop_front();
            checks++; if (bus.rx_data !== e) begin errors++; $display("FAIL mode%0d_rx: got %h expected %h", m, bus.rx_data, e); end
            e = exp_tx_q.pop_front();
            checks++; if (slv_rx !== e) begin errors++; $display("FAIL mode%0d_slave_rx: got %h expected %h", m, slv_rx, e); end
            checks++; if (slv_edges != 2 * W || slv_samples != W) begin errors++; $display("FAIL mode%0d_edges: got %0d/%0d expected %0d/%0d", m, slv_edges, slv_samples, 2 * W, W); end
            checks++; if (bus.sck !== 1'(m >> 1)) begin errors++; $display("FAIL mode%0d_sck_idle: got %b expected %b", m, bus.sck, 1'(m >> 1)); end
            @(negedge clk);
        end
    endtask

    task automatic test_lsb_first;
        int n; bit gl; logic [W-1:0] e;
        start_frame(8'h01, 2'b00, 1'b1, 8'h80);
        wait_done(FRAME_EDGES + 20, n, gl);
        checks++; if (n != FRAME_EDGES) begin errors++; $display("FAIL lsb_done_edge: got %0d expected %0d", n, FRAME_EDGES); end
        checks++; if (slv_first !== 1'b1) begin errors++; $display("FAIL lsb_first_bit: got %b expected 1", slv_first); end
        e = exp_tx_q.pop_front();
        checks++; if (slv_rx !== e) begin errors++; $display("FAIL lsb_mosi_word: got %h expected %h", slv_rx, e); end
        e = exp_rx_q.pop_front();
        checks++; if (bus.rx_data !== e) begin errors++; $display("FAIL lsb_rx: got %h expected %h", bus.rx_data, e); end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy;
        int n; int dcount; int dn; logic [W-1:0] got, e;
        start_frame(8'h5A, 2'b00, 1'b0, 8'hC3);
        n = 0; dcount = 0; dn = -1; got = '0;
        while (n < FRAME_EDGES + 30) begin
            if (n == 4 || n == 99) begin
                bus.start = 1'b1; bus.tx_data = 8'hFF; bus.mode = 2'b11;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin dcount++; dn = n; got = bus.rx_data; end
            @(negedge clk);
            n++;
        end
        bus.mode = 2'b00;
        checks++; if (dcount != 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", dcount); end
        checks++; if (dn != FRAME_EDGES) begin errors++; $display("FAIL busy_done_edge: got %0d expected %0d", dn, FRAME_EDGES); end
        e = exp_rx_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL busy_rx: got %h expected %h", got, e); end
        e = exp_tx_q.pop_front();
        checks++; if (slv_rx !== e) begin errors++; $display("FAIL busy_tx_word: got %h expected %h", slv_rx, e); end
    endtask

    task automatic test_reset_mid_frame;
        int n; bit gl; bit saw_done; logic [W-1:0] e;
        start_frame(8'h96, 2'b10, 1'b0, 8'h69);
        repeat (149) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (bus.cs_n !== 1'b1 || bus.busy !== 1'b0 || bus.sck !== 1'b0) begin errors++; $display("FAIL abort_pins: got cs_n=%b busy=%b sck=%b expected 1/0/0", bus.cs_n, bus.busy, bus.sck); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL abort_rx: got %h expected 00", bus.rx_data); end
        saw_done = 1'b0;
        repeat (3) begin @(negedge clk); if (bus.done === 1'b1) saw_done = 1'b1; end
        reset = 1'b0;
        repeat (3) begin @(negedge clk); if (bus.done === 1'b1) saw_done = 1'b1; end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got done pulse expected none"); end
        void'(exp_rx_q.pop_back());
        void'(exp_tx_q.pop_back());
        start_frame(8'h3C, 2'b10, 1'b0, 8'hE1);
        wait_done(FRAME_EDGES + 20, n, gl);
        checks++; if (n != FRAME_EDGES) begin errors++; $display("FAIL post_reset_done_edge: got %0d expected %0d", n, FRAME_EDGES); end
        e = exp_rx_q.pop_front();
        checks++; if (bus.rx_data !== e) begin errors++; $display("FAIL post_reset_rx: got %h expected %h", bus.rx_data, e); end
        e = exp_tx_q.pop_front();
        checks++; if (slv_rx !== e) begin errors++; $display("FAIL post_reset_tx: got %h expected %h", slv_rx, e); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [FW-1:0] fv[4];
        logic [FW-1:0] e;
        logic          exp_edge;
        int            frame;
        fv[0] = 4'h9; fv[1] = 4'h6; fv[2] = 4'hF; fv[3] = 4'h3;
        @(negedge clk);
        fbus.mode = 2'b00; fbus.lsb_first = 1'b0; fbus.tx_data = fv[0]; fbus.start = 1'b1;
        fexp_q.push_back(fv[0]);
        frame = 0;
        for (int k = 0; k < 44; k++) begin
            @(negedge clk);
            exp_edge = ((k % 11) == 10);
            checks++; if (fbus.done !== exp_edge) begin errors++; $display("FAIL b2b_done k=%0d: got %b expected %b", k, fbus.done, exp_edge); end
            checks++; if (fbus.cs_n !== exp_edge) begin errors++; $display("FAIL b2b_cs_n k=%0d: got %b expected %b", k, fbus.cs_n, exp_edge); end
            if (fbus.done === 1'b1) begin
                e = (fexp_q.size() > 0) ? fexp_q.pop_front() : 4'h0;
                checks++; if (fbus.rx_data !== e) begin errors++; $display("FAIL b2b_rx frame=%0d: got %h expected %h", frame, fbus.rx_data, e); end
                frame++;
                if (frame < 4) begin
                    fbus.tx_data = fv[frame];
                    fexp_q.push_back(fv[frame]);
                end else begin
                    fbus.start = 1'b0;
                end
            end
        end
        checks++; if (frame != 4) begin errors++; $display("FAIL b2b_frames: got %0d expected 4", frame); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_lsb_first();
        test_start_while_busy();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
